fp32_sign_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one IEEE-754 single-precision sign classifier among several battery-monitor requesters (cell current, pack current, balancing shunt readings). Each requester presents a 32-bit float over a valid/ready handshake. The block grants one request at a time, registers the sign classification (greater than, less than, or equal to zero, plus NaN) and returns it with the requester ID over a second valid/ready handshake. It sits between the measurement front-ends and the charge/discharge state logic.

---
 rtl/battery_pkg.sv | 28 ++
 rtl/fp32_sign_classify.sv | 28 ++
 rtl/fp32_sign_arbiter.sv | 128 ++++++++++++
 tb/tb_fp32_sign_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battery_pkg.sv
// Shared definitions for the battery-monitor datapath: FP32 field layout,
// arbiter FSM states and the sign classification record.
package battery_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;
  localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;
  localparam int MAN_W    = MAN_MSB - MAN_LSB + 1;

  localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    RESP
  } arb_state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
    logic nan;
  } sign_class_t;

endpackage

// File: rtl/fp32_sign_classify.sv
// Combinational sign classifier for one IEEE-754 single-precision word.
// Zero of either sign is eq, any NaN payload is nan, everything else follows the sign bit.
module fp32_sign_classify
  import battery_pkg::*;
(
  input  logic [31:0]  word,
  output sign_class_t  cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  always_comb begin
    exp_f = word[EXP_MSB:EXP_LSB];
    man_f = word[MAN_MSB:MAN_LSB];
    cls   = '0;
    if (exp_f == '0 && man_f == '0) begin
      cls.eq = 1'b1;
    end else if (exp_f == EXP_ALL_ONES && man_f != '0) begin
      cls.nan = 1'b1;
    end else if (word[SIGN_BIT]) begin
      cls.lt = 1'b1;
    end else begin
      cls.gt = 1'b1;
    end
  end

endmodule

// File: rtl/fp32_sign_arbiter.sv
// Round-robin arbiter sharing one fp32_sign_classify among N_REQ requesters.
// One request per IDLE visit: accept, evaluate, then hold the result until consumed.
module fp32_sign_arbiter
  import battery_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_gt,
  output logic                 rsp_lt,
  output logic                 rsp_eq,
  output logic                 rsp_nan,
  output logic                 busy
);

  // First set bit at or above start, wrapping past N_REQ-1 back to 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  start);
    logic [ID_W-1:0] winner;
    logic            found;
    int              idx;
    winner = start;
    found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(start) + i) % N_REQ;
      if (!found && valid[ID_W'(idx)]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

  arb_state_t       state, state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  ptr_nxt;
  logic [ID_W-1:0]  cap_id;
  logic [31:0]      cap_data;
  logic [31:0]      req_word [N_REQ];
  logic             grant;
  logic             rsp_fire;
  sign_class_t      cls;
  sign_class_t      rsp_class;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_word[i] = req_data[32*i +: 32];
    end
  end

  assign winner   = rr_pick(req_valid, ptr);
  assign grant    = (state == IDLE) && (|req_valid);
  assign rsp_fire = (state == RESP) && rsp_valid && rsp_ready;
  assign ptr_nxt  = (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  fp32_sign_classify u_classify (
    .word (cap_data),
    .cls  (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are cleared on handshake so they are only ever seen alongside rsp_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cap_id    <= '0;
      cap_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_class <= '0;
    end else begin
      if (grant) begin
        cap_id   <= winner;
        cap_data <= req_word[winner];
      end
      if (state == EVAL) begin
        rsp_valid <= 1'b1;
        rsp_id    <= cap_id;
        rsp_class <= cls;
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        rsp_class <= '0;
        ptr       <= ptr_nxt;
      end
    end
  end

  assign rsp_gt  = rsp_class.gt;
  assign rsp_lt  = rsp_class.lt;
  assign rsp_eq  = rsp_class.eq;
  assign rsp_nan = rsp_class.nan;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_fp32_sign_arbiter.sv
// Directed self-checking bench for fp32_sign_arbiter with four requesters.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_fp32_sign_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk;
  logic                rst_n;
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_gt, rsp_lt, rsp_eq, rsp_nan;
  logic                busy;

  int checks;
  int errors;

  fp32_sign_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_lt    (rsp_lt),
    .rsp_eq    (rsp_eq),
    .rsp_nan   (rsp_nan),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full view: {rsp_valid, rsp_id, gt, lt, eq, nan, busy, req_ready}
  function automatic logic [11:0] snap();
    return {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, rsp_nan, busy, req_ready};
  endfunction

  // Handshake view: {rsp_valid, busy, req_ready}
  function automatic logic [5:0] hs_snap();
    return {rsp_valid, busy, req_ready};
  endfunction

  task automatic applyReset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (snap() !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", snap(), 12'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (hs_snap() !== 6'b0) begin
        errors++;
        $display("[TB] FAIL idle_no_request: got %b expected %b", hs_snap(), 6'b0);
      end
    end
  endtask

  task automatic test_single_requester();
    logic [31:0] words [7];
    logic [3:0]  flags [7];
    words = '{32'h00000000, 32'h80000000, 32'h40800000, 32'hC0800000,
              32'h7FC00000, 32'h00000001, 32'hFF800000};
    flags = '{4'b0010, 4'b0010, 4'b1000, 4'b0100, 4'b0001, 4'b1000, 4'b0100};
    applyReset();
    for (int i = 0; i < 7; i++) begin
      req_data[31:0] = words[i];
      req_valid      = 4'b0001;
      #1;
      checks++;
      if (hs_snap() !== {1'b0, 1'b0, 4'b0001}) begin
        errors++;
        $display("[TB] FAIL single_grant[%0d]: got %b expected %b", i, hs_snap(), {1'b0, 1'b0, 4'b0001});
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if (hs_snap() !== {1'b0, 1'b1, 4'b0000}) begin
        errors++;
        $display("[TB] FAIL single_eval[%0d]: got %b expected %b", i, hs_snap(), {1'b0, 1'b1, 4'b0000});
      end
      @(negedge clk);
      #1;
      checks++;
      if (snap() !== {1'b1, 2'd0, flags[i], 1'b1, 4'b0000}) begin
        errors++;
        $display("[TB] FAIL single_resp[%0d] word %h: got %h expected %h", i, words[i], snap(), {1'b1, 2'd0, flags[i], 1'b1, 4'b0000});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] flags [4];
    logic [1:0] e;
    flags = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    applyReset();
    req_data  = {32'h7F800001, 32'h80000000, 32'hBF800000, 32'h3F800000};
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      e = 2'(k % 4);
      #1;
      checks++;
      if (req_ready !== (4'b0001 << e)) begin
        errors++;
        $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, 4'b0001 << e);
      end
      @(negedge clk);
      #1;
      checks++;
      if (hs_snap() !== {1'b0, 1'b1, 4'b0000}) begin
        errors++;
        $display("[TB] FAIL rr_eval[%0d]: got %b expected %b", k, hs_snap(), {1'b0, 1'b1, 4'b0000});
      end
      @(negedge clk);
      #1;
      checks++;
      if (snap() !== {1'b1, e, flags[e], 1'b1, 4'b0000}) begin
        errors++;
        $display("[TB] FAIL rr_resp[%0d]: got %h expected %h", k, snap(), {1'b1, e, flags[e], 1'b1, 4'b0000});
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    applyReset();
    req_data  = {32'hC0800000, 32'h00000000, 32'h40800000, 32'h00000000};
    req_valid = 4'b0010;
    #1;
    checks++;
    if (hs_snap() !== {1'b0, 1'b0, 4'b0010}) begin
      errors++;
      $display("[TB] FAIL wrap_prime_grant: got %b expected %b", hs_snap(), {1'b0, 1'b0, 4'b0010});
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (snap() !== {1'b1, 2'd1, 4'b1000, 1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL wrap_prime_resp: got %h expected %h", snap(), {1'b1, 2'd1, 4'b1000, 1'b1, 4'b0000});
    end
    req_valid = 4'b1010;
    @(negedge clk);
    #1;
    checks++;
    if (hs_snap() !== {1'b0, 1'b0, 4'b1000}) begin
      errors++;
      $display("[TB] FAIL wrap_first_grant: got %b expected %b", hs_snap(), {1'b0, 1'b0, 4'b1000});
    end
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    #1;
    checks++;
    if (snap() !== {1'b1, 2'd3, 4'b0100, 1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL wrap_first_resp: got %h expected %h", snap(), {1'b1, 2'd3, 4'b0100, 1'b1, 4'b0000});
    end
    @(negedge clk);
    #1;
    checks++;
    if (hs_snap() !== {1'b0, 1'b0, 4'b0010}) begin
      errors++;
      $display("[TB] FAIL wrap_second_grant: got %b expected %b", hs_snap(), {1'b0, 1'b0, 4'b0010});
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (snap() !== {1'b1, 2'd1, 4'b1000, 1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL wrap_second_resp: got %h expected %h", snap(), {1'b1, 2'd1, 4'b1000, 1'b1, 4'b0000});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    applyReset();
    rsp_ready       = 1'b0;
    req_data[31:0]  = 32'hC0800000;
    req_valid       = 4'b0001;
    #1;
    checks++;
    if (hs_snap() !== {1'b0, 1'b0, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL bp_grant: got %b expected %b", hs_snap(), {1'b0, 1'b0, 4'b0001});
    end
    @(negedge clk);
    req_data[63:32] = 32'h3F800000;
    req_valid       = 4'b0010;
    #1;
    checks++;
    if (hs_snap() !== {1'b0, 1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL bp_eval: got %b expected %b", hs_snap(), {1'b0, 1'b1, 4'b0000});
    end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (snap() !== {1'b1, 2'd0, 4'b0100, 1'b1, 4'b0000}) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got %h expected %h", c, snap(), {1'b1, 2'd0, 4'b0100, 1'b1, 4'b0000});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (snap() !== {1'b1, 2'd0, 4'b0100, 1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL bp_handshake_cycle: got %h expected %h", snap(), {1'b1, 2'd0, 4'b0100, 1'b1, 4'b0000});
    end
    @(negedge clk);
    #1;
    checks++;
    if (hs_snap() !== {1'b0, 1'b0, 4'b0010}) begin
      errors++;
      $display("[TB] FAIL bp_next_grant: got %b expected %b", hs_snap(), {1'b0, 1'b0, 4'b0010});
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (snap() !== {1'b1, 2'd1, 4'b1000, 1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL bp_next_resp: got %h expected %h", snap(), {1'b1, 2'd1, 4'b1000, 1'b1, 4'b0000});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_during_eval();
    applyReset();
    req_data  = {32'h40800000, 32'h7FC00000, 32'h00000000, 32'hC0800000};
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (snap() !== {1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL rst_prime_resp: got %h expected %h", snap(), {1'b1, 2'd1, 4'b0010, 1'b1, 4'b0000});
    end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (hs_snap() !== {1'b0, 1'b0, 4'b0100}) begin
      errors++;
      $display("[TB] FAIL rst_grant: got %b expected %b", hs_snap(), {1'b0, 1'b0, 4'b0100});
    end
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    checks++;
    if (snap() !== 12'h000) begin
      errors++;
      $display("[TB] FAIL rst_in_eval: got %h expected %h", snap(), 12'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (hs_snap() !== 6'b0) begin
        errors++;
        $display("[TB] FAIL rst_no_response[%0d]: got %b expected %b", c, hs_snap(), 6'b0);
      end
      @(negedge clk);
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (hs_snap() !== {1'b0, 1'b0, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL rst_ptr_zero: got %b expected %b", hs_snap(), {1'b0, 1'b0, 4'b0001});
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (snap() !== {1'b1, 2'd0, 4'b0100, 1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL rst_after_resp: got %h expected %h", snap(), {1'b1, 2'd0, 4'b0100, 1'b1, 4'b0000});
    end
    @(negedge clk);
  endtask

  task automatic test_dropped_valid();
    applyReset();
    req_data  = {32'h00000000, 32'hC0800000, 32'h00000000, 32'h40800000};
    req_valid = 4'b0101;
    #1;
    checks++;
    if (hs_snap() !== {1'b0, 1'b0, 4'b0001}) begin
      errors++;
      $display("[TB] FAIL drop_grant: got %b expected %b", hs_snap(), {1'b0, 1'b0, 4'b0001});
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (snap() !== {1'b1, 2'd0, 4'b1000, 1'b1, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL drop_resp: got %h expected %h", snap(), {1'b1, 2'd0, 4'b1000, 1'b1, 4'b0000});
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (hs_snap() !== 6'b0) begin
        errors++;
        $display("[TB] FAIL drop_never_served[%0d]: got %b expected %b", c, hs_snap(), 6'b0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_requester();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_reset_during_eval();
    test_dropped_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
